// File: rtl/edge_window_feeder.sv
// Raster stream -> 2x2 window + bilinear weights; 1-cycle latency from accepted pixel, no backpressure (gaps hold state).
// EDGE_BORDER_REPLICATE_EN: also emit row-0/col-0 windows with missing neighbours replicated.
module edge_window_feeder #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DW    = 16,
  parameter int FRAC  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   pix_in,
  input  logic            pix_vld,
  input  logic            sof,
  input  logic [FRAC-1:0] frac_x,
  input  logic [FRAC-1:0] frac_y,
  output logic [DW-1:0]   imgmn,
  output logic [DW-1:0]   imgm1n,
  output logic [DW-1:0]   imgmn1,
  output logic [DW-1:0]   imgm1n1,
  output logic [DW-1:0]   Amn,
  output logic [DW-1:0]   Am1n,
  output logic [DW-1:0]   Amn1,
  output logic [DW-1:0]   Am1n1,
  output logic            img_rdy,
  output logic            frame_done
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int PW = 2 * FRAC + 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [FRAC:0] UNITY    = {1'b1, {FRAC{1'b0}}};

  logic [CW-1:0]   col_q, col_d, cur_c;
  logic [RW-1:0]   row_q, row_d, cur_r;
  logic [FRAC-1:0] fx_q, fx_d, fy_q, fy_d;
  logic [DW-1:0]   prev_pix_q, prev_pix_d;
  logic [DW-1:0]   prev_lb_q, prev_lb_d;
  logic [DW-1:0]   imgmn_q, imgmn_d, imgm1n_q, imgm1n_d;
  logic [DW-1:0]   imgmn1_q, imgmn1_d, imgm1n1_q, imgm1n1_d;
  logic [DW-1:0]   amn_q, amn_d, am1n_q, am1n_d, amn1_q, amn1_d, am1n1_q, am1n1_d;
  logic            img_rdy_q, img_rdy_d, frame_done_q, frame_done_d;
  logic [DW-1:0]   linebuf_q [IMG_W];

  logic            acc, emit, first_row, first_col;
  logic [DW-1:0]   lb_rd, up_cur, left_cur, up_left;
  logic [FRAC:0]   ix, iy, fx_ext, fy_ext;
  logic [PW-1:0]   p_mn, p_m1n, p_mn1, p_m1n1;

  always_comb begin
    acc       = pix_vld;
    cur_c     = sof ? '0 : col_q;
    cur_r     = sof ? '0 : row_q;
    first_row = (cur_r == '0);
    first_col = (cur_c == '0);
    lb_rd     = linebuf_q[cur_c];

    // A new frame's offsets must already apply to its own (0,0) window.
    fx_d = (acc && sof) ? frac_x : fx_q;
    fy_d = (acc && sof) ? frac_y : fy_q;

    fx_ext = {1'b0, fx_d};
    fy_ext = {1'b0, fy_d};
    ix     = UNITY - fx_ext;
    iy     = UNITY - fy_ext;
    p_mn   = PW'(ix) * PW'(iy);
    p_m1n  = PW'(ix) * PW'(fy_ext);
    p_mn1  = PW'(fx_ext) * PW'(iy);
    p_m1n1 = PW'(fx_ext) * PW'(fy_ext);

`ifdef EDGE_BORDER_REPLICATE_EN
    emit     = 1'b1;
    up_cur   = first_row ? pix_in : lb_rd;
    left_cur = first_col ? pix_in : prev_pix_q;
    if (first_col) begin
      up_left = up_cur;
    end else begin
      up_left = first_row ? prev_pix_q : prev_lb_q;
    end
`else
    emit     = !first_row && !first_col;
    up_cur   = lb_rd;
    left_cur = prev_pix_q;
    up_left  = prev_lb_q;
`endif

    col_d        = col_q;
    row_d        = row_q;
    prev_pix_d   = prev_pix_q;
    prev_lb_d    = prev_lb_q;
    imgmn_d      = imgmn_q;
    imgm1n_d     = imgm1n_q;
    imgmn1_d     = imgmn1_q;
    imgm1n1_d    = imgm1n1_q;
    amn_d        = amn_q;
    am1n_d       = am1n_q;
    amn1_d       = amn1_q;
    am1n1_d      = am1n1_q;
    img_rdy_d    = 1'b0;
    frame_done_d = 1'b0;

    if (acc) begin
      if (cur_c == COL_LAST) begin
        col_d = '0;
        row_d = (cur_r == ROW_LAST) ? '0 : cur_r + 1'b1;
      end else begin
        col_d = cur_c + 1'b1;
        row_d = cur_r;
      end
      prev_pix_d = pix_in;
      prev_lb_d  = lb_rd;
      if (emit) begin
        imgm1n1_d    = pix_in;
        imgm1n_d     = left_cur;
        imgmn1_d     = up_cur;
        imgmn_d      = up_left;
        amn_d        = DW'(p_mn >> FRAC);
        am1n_d       = DW'(p_m1n >> FRAC);
        amn1_d       = DW'(p_mn1 >> FRAC);
        am1n1_d      = DW'(p_m1n1 >> FRAC);
        img_rdy_d    = 1'b1;
        frame_done_d = (cur_c == COL_LAST) && (cur_r == ROW_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      fx_q         <= '0;
      fy_q         <= '0;
      prev_pix_q   <= '0;
      prev_lb_q    <= '0;
      imgmn_q      <= '0;
      imgm1n_q     <= '0;
      imgmn1_q     <= '0;
      imgm1n1_q    <= '0;
      amn_q        <= '0;
      am1n_q       <= '0;
      amn1_q       <= '0;
      am1n1_q      <= '0;
      img_rdy_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      fx_q         <= fx_d;
      fy_q         <= fy_d;
      prev_pix_q   <= prev_pix_d;
      prev_lb_q    <= prev_lb_d;
      imgmn_q      <= imgmn_d;
      imgm1n_q     <= imgm1n_d;
      imgmn1_q     <= imgmn1_d;
      imgm1n1_q    <= imgm1n1_d;
      amn_q        <= amn_d;
      am1n_q       <= am1n_d;
      amn1_q       <= amn1_d;
      am1n1_q      <= am1n1_d;
      img_rdy_q    <= img_rdy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Contents are never read before row 0 of a frame rewrites them, so no reset.
  always_ff @(posedge clk) begin
    if (acc) begin
      linebuf_q[cur_c] <= pix_in;
    end
  end

  assign imgmn      = imgmn_q;
  assign imgm1n     = imgm1n_q;
  assign imgmn1     = imgmn1_q;
  assign imgm1n1    = imgm1n1_q;
  assign Amn        = amn_q;
  assign Am1n       = am1n_q;
  assign Amn1       = amn1_q;
  assign Am1n1      = am1n1_q;
  assign img_rdy    = img_rdy_q;
  assign frame_done = frame_done_q;

endmodule
